counter_add_arbiter: RTL
========================

# counter_add_arbiter

Round-robin arbiter and sequencer that shares the `addStart`/`para` offset-add port of the 32-bit counter among `NREQ` requesters. It picks one pending requester and latches its 8-bit offset onto `para`. It then issues a single-cycle `addStart` pulse and acknowledges the winner. A programmable settle gap follows before the next grant. It sits between the soft processor's offset sources (branch unit, interrupt vectoring, debug) and `counter_32Bit`.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `OFF_W`, 8: offset width; must match counter `para` width.
- `GAP`, 2: idle cycles forced after each add pulse, 0..15.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `en`  in  1  grant enable; low blocks new grants only.
- `req`  in  NREQ  request vector; bit i held high by requester i until its ack.
- `offset`  in  NREQ*OFF_W  requester i offset at bits [i*OFF_W +: OFF_W].
- `ack`  out  NREQ  one-hot, one-cycle grant acknowledge.
- `addStart`  out  1  add strobe to the counter.
- `para`  out  OFF_W  registered offset to the counter.
- `busy`  out  1  high when the FSM is not IDLE.
- `grant_id`  out  clog2(NREQ)  index of the last granted requester.

## Operation
- FSM states: IDLE, ISSUE, SETTLE.
- IDLE: at an edge with `en`=1 and `req`≠0:
  - Select the winner by round-robin, scanning from `grant_id`+1 upward with modulo NREQ wrap.
  - On that edge: `para` <= `offset[winner]`, `addStart` <= 1, `ack[winner]` <= 1, `grant_id` <= winner, state -> ISSUE.
- ISSUE lasts exactly one cycle. The next edge clears `addStart` and `ack`.
  - GAP>0: state -> SETTLE with a down-counter loaded to GAP-1.
  - GAP=0: state -> IDLE.
- SETTLE: the counter decrements each edge. The edge at which it reads 0 moves the state to IDLE. `req` and `en` are ignored in SETTLE.
- `para` holds its last value between grants and is never cleared except by reset.
- `busy` is decoded combinationally from the state register and is high in ISSUE and SETTLE.
- A requester deasserts `req` in the cycle after its ack. A `req` held after ack is treated as a new request at the next IDLE evaluation.
- Offset 0 is granted and pulsed normally; the counter adds zero.
- A request withdrawn before being sampled in IDLE is simply not granted. No state is retained for it.
- `en` falling during ISSUE or SETTLE: the current pulse and gap complete, then the FSM stays in IDLE until `en`=1.

## Timing
- Reset (asynchronous, `reset`=0) forces these values immediately:
  - State: IDLE.
  - Outputs: `addStart`=0, `ack`=0, `para`=0, `busy`=0, `grant_id`=NREQ-1, so requester 0 wins first after reset.
- Reset mid-ISSUE drops `addStart` and `ack` in the same instant. That add is lost.
- Grant latency: `req` sampled high in IDLE at edge k gives `addStart`, `ack` and `para` valid from edge k to edge k+1.
- Throughput: with continuous requests, `addStart` is high for 1 of every GAP+2 cycles. With GAP=0 that is every 2nd cycle.
- `addStart` is never high in two consecutive cycles.
- `ack` is never high outside an `addStart` cycle, and never has more than one bit set.
- `offset` only needs to be stable at the grant edge.

## Test plan
- Reset: assert `reset`=0 for 10 ns while in ISSUE with `para`=8'h28 -> `addStart`=0, `ack`=0, `para`=8'h00, `busy`=0, `grant_id`=3 at once; first grant after release goes to requester 0.
- Single request (GAP=2): `req`=4'b0100 with offset 8'h28 -> one 1-cycle `addStart` with `para`=8'h28 and `ack`=4'b0100. With `counter_32Bit` attached, `count` rises by 0x28; `busy` is high for 3 cycles.
- Full load (GAP=2): all four `req` held, offsets 1,2,3,4 -> grants 0,1,2,3,0,… every 4 cycles; `count` rises by 10 every 16 cycles.
- Fairness: `req`=4'b1001 held -> `grant_id` alternates 0,3,0,3; neither requester is granted twice in a row.
- Enable gating: `req`=4'b0010 with `en`=0 for 20 cycles -> no `addStart`. Raising `en` gives a grant on the next IDLE edge. Dropping `en` during SETTLE lets the gap complete, then no further grants.
- GAP=0 build: `req`=4'b0001 held -> `addStart` toggles 1,0,1,0 and `para` stays at the offset.

Source files
------------

// File: rtl/counter_add_arbiter_if.sv
// Requester-side bundle for the counter offset-add arbiter.
// The arbiter connects through the slave modport; the requester side uses master.
interface counter_add_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned OFF_W = 8
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic                  en;
  logic [NREQ-1:0]       req;
  logic [NREQ*OFF_W-1:0] offset;
  logic [NREQ-1:0]       ack;
  logic                  addStart;
  logic [OFF_W-1:0]      para;
  logic                  busy;
  logic [IDW-1:0]        grant_id;

  modport slave (
    input  en, req, offset,
    output ack, addStart, para, busy, grant_id
  );

  modport master (
    output en, req, offset,
    input  ack, addStart, para, busy, grant_id
  );
endinterface

// File: rtl/counter_add_arbiter.sv
// Round-robin arbiter sharing the counter's addStart/para offset-add port,
// with a one-cycle add pulse followed by a programmable settle gap.
module counter_add_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned OFF_W = 8,
  parameter int unsigned GAP   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  counter_add_arbiter_if.slave  bus
);
  localparam int unsigned IDW    = $clog2(NREQ);
  localparam logic [3:0]  GAP_LD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

  state_t            state, state_n;
  logic [3:0]        gap_cnt, gap_cnt_n;
  logic [OFF_W-1:0]  para_q, para_n;
  logic              add_q, add_n;
  logic [NREQ-1:0]   ack_q, ack_n;
  logic [IDW-1:0]    gid_q, gid_n;
  logic [IDW-1:0]    win, cand;
  logic              found;
  int unsigned       idx;

  // Scan from the requester after the last winner, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = gid_q;
    cand  = '0;
    idx   = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx  = (32'(gid_q) + k) % NREQ;
      cand = IDW'(idx);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_n   = state;
    gap_cnt_n = gap_cnt;
    para_n    = para_q;
    add_n     = 1'b0;
    ack_n     = '0;
    gid_n     = gid_q;
    case (state)
      IDLE: begin
        if (bus.en && found) begin
          para_n     = bus.offset[win*OFF_W +: OFF_W];
          add_n      = 1'b1;
          ack_n[win] = 1'b1;
          gid_n      = win;
          state_n    = ISSUE;
        end
      end
      ISSUE: begin
        if (GAP > 0) begin
          state_n   = SETTLE;
          gap_cnt_n = GAP_LD;
        end else begin
          state_n = IDLE;
        end
      end
      SETTLE: begin
        if (gap_cnt == 4'd0) state_n = IDLE;
        else                 gap_cnt_n = gap_cnt - 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      gap_cnt <= '0;
      para_q  <= '0;
      add_q   <= 1'b0;
      ack_q   <= '0;
      gid_q   <= IDW'(NREQ - 1);
    end else begin
      state   <= state_n;
      gap_cnt <= gap_cnt_n;
      para_q  <= para_n;
      add_q   <= add_n;
      ack_q   <= ack_n;
      gid_q   <= gid_n;
    end
  end

  assign bus.addStart = add_q;
  assign bus.ack      = ack_q;
  assign bus.para     = para_q;
  assign bus.grant_id = gid_q;
  assign bus.busy     = (state != IDLE);
endmodule
